rd_pipeline_tracker: RTL and testbench
======================================

Name: rd_pipeline_tracker

Overview:
Tracks destination-register metadata (RD, RF write enable, load flag) for the instruction stream through the EX, MEM and WB stages. Its EX/MEM/WB outputs are the inputs the forwarding unit compares against ID source registers. It consumes the forwarding unit's load-use outputs (FW_LE_SIGNAL, FW_CU_MUX_SIGNAL): it converts them into PC and IF/ID load enables and bubble insertion, and it sequences branch flushes. It also keeps saturating stall and bubble performance counters and a sticky protocol-error flag.

Parameters:
REG_W, 4, register-index width
CNT_W, 16, width of performance counters

Ports:
clk  input  1  clock, rising edge
reset  input  1  synchronous, active-high reset
ID_RD  input  REG_W  destination register of the instruction in ID
ID_RF_enable  input  1  instruction in ID writes the register file
ID_load_instr  input  1  instruction in ID is a load
FW_LE_SIGNAL  input  1  from forwarding unit; 1 = pipeline may advance
FW_CU_MUX_SIGNAL  input  1  from forwarding unit; 1 = inject NOP into EX
flush  input  1  taken branch resolved in ID; squash instruction in IF/ID
EX_RD, MEM_RD, WB_RD  output  REG_W each  stage destination registers
EX_RF_enable, MEM_RF_enable, WB_RF_enable  output  1 each  stage RF write enables; WB_RF_enable also drives the register-file write strobe
EX_load_instr, MEM_load_instr  output  1 each  stage load flags
PC_LE  output  1  PC load enable
IFID_LE  output  1  IF/ID register load enable
IFID_clear  output  1  IF/ID synchronous clear (NOP)
stall_cnt  output  CNT_W  cycles stalled, saturating
bubble_cnt  output  CNT_W  bubbles injected, saturating
protocol_err  output  1  sticky: illegal FW signal combination seen

Behaviour:
- Reset (reset=1 at a rising edge): all stage RD registers = 0, all RF_enable/load flags = 0, stall_cnt = 0, bubble_cnt = 0, protocol_err = 0. Reset takes precedence over every other input. Reset asserted mid-stall discards all in-flight stage contents.
- Combinational outputs: PC_LE and IFID_LE are combinational; all other outputs are registered.
- Derived signals, evaluated every cycle:
  - stall = ~FW_LE_SIGNAL | FW_CU_MUX_SIGNAL
  - bubble = FW_CU_MUX_SIGNAL | ~FW_LE_SIGNAL. Any stall forces a bubble into EX, because ID is held and must not issue twice.
- Advance (each rising edge, no reset):
  - MEM stage <= EX stage, then WB stage <= MEM stage. These shifts are unconditional: EX/MEM/WB never stall.
  - EX stage <= bubble ? {RD=0, RF_enable=0, load=0} : {ID_RD, ID_RF_enable, ID_load_instr}.
- Enables and flush:
  - PC_LE = IFID_LE = ~stall.
  - IFID_clear = flush & ~stall. A flush arriving during a stall is ignored that cycle; the ID stage re-presents flush once the stall clears.
- Latency: ID metadata appears on EX outputs 1 cycle after capture, MEM after 2, WB after 3. A load-use stall lasts exactly 1 cycle in a normal sequence, because the load moves to MEM and the forwarding unit deasserts.
- Counters:
  - stall_cnt increments by 1 on every cycle with stall=1.
  - bubble_cnt increments by 1 on every cycle with bubble=1.
  - Both hold at all-ones (saturate) and never wrap.
- protocol_err: set on any cycle where FW_LE_SIGNAL == FW_CU_MUX_SIGNAL. It stays set until reset. The pipeline still follows the stall/bubble rule above in that cycle.
- A bubble always carries RF_enable=0, so WB_RF_enable never writes register 0 spuriously.

Test Plan:
- Reset: hold reset 2 cycles with ID_RF_enable=1, ID_RD=5 -> all stage outputs 0, counters 0, protocol_err 0. Release with FW_LE=1, FW_CU=0 -> EX_RD=5, EX_RF_enable=1 one cycle later; WB_RD=5 three cycles later.
- Load-use stall: ID load RD=3, then dependent instruction; FW_CU=1 and FW_LE=0 for 1 cycle -> PC_LE=IFID_LE=0 that cycle; EX shows a bubble (RF_enable=0, RD=0); MEM_load_instr=1, MEM_RD=3; stall_cnt=1, bubble_cnt=1.
- Flush: flush=1 with FW_LE=1 -> IFID_clear=1 for that cycle only. Flush=1 together with FW_CU=1 -> IFID_clear=0, PC_LE=0.
- Back-to-back: stream of RD=1,2,3,4, each with RF_enable=1 -> EX/MEM/WB show 4,3,2 on the cycle ID presents the next instruction; no bubbles, counters stay 0.
- Protocol error: FW_LE=0, FW_CU=0 for 1 cycle -> protocol_err=1 and stays 1; bubble injected. A subsequent reset clears it.
- Saturation: with CNT_W=4, hold stall for 20 cycles -> stall_cnt=15 and bubble_cnt=15, and both stay there.

Source files
------------

// File: rtl/rd_pipeline_tracker.sv
// Carries RD / RF-write / load metadata through EX, MEM and WB (1/2/3 cycles after ID) and turns forwarding-unit load-use signals into stalls.
// PC_LE and IFID_LE are combinational; EX/MEM/WB never stall, so a held ID stage is covered by an EX bubble.
module rd_pipeline_tracker #(
    parameter int REG_W = 4,
    parameter int CNT_W = 16
) (
    input  logic             clk,
    input  logic             reset,
    input  logic [REG_W-1:0] ID_RD,
    input  logic             ID_RF_enable,
    input  logic             ID_load_instr,
    input  logic             FW_LE_SIGNAL,
    input  logic             FW_CU_MUX_SIGNAL,
    input  logic             flush,
    output logic [REG_W-1:0] EX_RD,
    output logic [REG_W-1:0] MEM_RD,
    output logic [REG_W-1:0] WB_RD,
    output logic             EX_RF_enable,
    output logic             MEM_RF_enable,
    output logic             WB_RF_enable,
    output logic             EX_load_instr,
    output logic             MEM_load_instr,
    output logic             PC_LE,
    output logic             IFID_LE,
    output logic             IFID_clear,
    output logic [CNT_W-1:0] stall_cnt,
    output logic [CNT_W-1:0] bubble_cnt,
    output logic             protocol_err
);

    logic stall;
    logic bubble;

    // Any stall also bubbles EX: ID is held and must not issue twice.
    assign stall   = ~FW_LE_SIGNAL | FW_CU_MUX_SIGNAL;
    assign bubble  = FW_CU_MUX_SIGNAL | ~FW_LE_SIGNAL;
    assign PC_LE   = ~stall;
    assign IFID_LE = ~stall;

    always_ff @(posedge clk) begin
        if (reset) begin
            EX_RD          <= '0;
            MEM_RD         <= '0;
            WB_RD          <= '0;
            EX_RF_enable   <= 1'b0;
            MEM_RF_enable  <= 1'b0;
            WB_RF_enable   <= 1'b0;
            EX_load_instr  <= 1'b0;
            MEM_load_instr <= 1'b0;
            IFID_clear     <= 1'b0;
            stall_cnt      <= '0;
            bubble_cnt     <= '0;
            protocol_err   <= 1'b0;
        end else begin
            WB_RD          <= MEM_RD;
            WB_RF_enable   <= MEM_RF_enable;
            MEM_RD         <= EX_RD;
            MEM_RF_enable  <= EX_RF_enable;
            MEM_load_instr <= EX_load_instr;
            if (bubble) begin
                EX_RD         <= '0;
                EX_RF_enable  <= 1'b0;
                EX_load_instr <= 1'b0;
            end else begin
                EX_RD         <= ID_RD;
                EX_RF_enable  <= ID_RF_enable;
                EX_load_instr <= ID_load_instr;
            end
            // A flush seen during a stall is dropped; ID re-presents it later.
            IFID_clear <= flush & ~stall;
            if (stall && (stall_cnt != '1))
                stall_cnt <= stall_cnt + CNT_W'(1);
            if (bubble && (bubble_cnt != '1))
                bubble_cnt <= bubble_cnt + CNT_W'(1);
            if (FW_LE_SIGNAL == FW_CU_MUX_SIGNAL)
                protocol_err <= 1'b1;
        end
    end

endmodule

// File: tb/tb_rd_pipeline_tracker.sv
// Scoreboard bench for rd_pipeline_tracker, built with 4-bit counters so saturation is reachable.
module tb_rd_pipeline_tracker;

    typedef struct packed {
        logic [3:0] rd;
        logic       we;
        logic       ld;
    } st_t;

    logic       clk = 1'b0;
    logic       reset;
    logic [3:0] ID_RD;
    logic       ID_RF_enable, ID_load_instr;
    logic       FW_LE_SIGNAL, FW_CU_MUX_SIGNAL, flush;
    logic [3:0] EX_RD, MEM_RD, WB_RD;
    logic       EX_RF_enable, MEM_RF_enable, WB_RF_enable;
    logic       EX_load_instr, MEM_load_instr;
    logic       PC_LE, IFID_LE, IFID_clear;
    logic [3:0] stall_cnt, bubble_cnt;
    logic       protocol_err;

    int n_pass = 0;
    int n_total = 0;

    st_t ex_q[$];
    st_t m_ex, m_mem, m_wb;
    int  m_stall, m_bub;
    logic m_perr, m_clr;

    rd_pipeline_tracker #(.REG_W(4), .CNT_W(4)) dut (
        .clk(clk), .reset(reset),
        .ID_RD(ID_RD), .ID_RF_enable(ID_RF_enable), .ID_load_instr(ID_load_instr),
        .FW_LE_SIGNAL(FW_LE_SIGNAL), .FW_CU_MUX_SIGNAL(FW_CU_MUX_SIGNAL), .flush(flush),
        .EX_RD(EX_RD), .MEM_RD(MEM_RD), .WB_RD(WB_RD),
        .EX_RF_enable(EX_RF_enable), .MEM_RF_enable(MEM_RF_enable), .WB_RF_enable(WB_RF_enable),
        .EX_load_instr(EX_load_instr), .MEM_load_instr(MEM_load_instr),
        .PC_LE(PC_LE), .IFID_LE(IFID_LE), .IFID_clear(IFID_clear),
        .stall_cnt(stall_cnt), .bubble_cnt(bubble_cnt), .protocol_err(protocol_err)
    );

    always #5 clk = ~clk;

    // Drive one ID instruction plus FW/flush inputs and queue the EX contents they should produce.
    task automatic set_in(input logic [3:0] rd, input logic we, input logic ld,
                          input logic le, input logic cu, input logic fl);
        st_t e;
        ID_RD = rd; ID_RF_enable = we; ID_load_instr = ld;
        FW_LE_SIGNAL = le; FW_CU_MUX_SIGNAL = cu; flush = fl;
        if (cu | ~le) e = '0;
        else begin
            e.rd = rd; e.we = we; e.ld = ld;
        end
        if (!reset) ex_q.push_back(e);
    endtask

    // One clock edge; the model advances the same way the pipeline should.
    task automatic tick();
        logic st, pe, cl;
        st = ~FW_LE_SIGNAL | FW_CU_MUX_SIGNAL;
        pe = (FW_LE_SIGNAL == FW_CU_MUX_SIGNAL);
        cl = flush & ~st;
        @(posedge clk);
        #1;
        if (reset) begin
            m_ex = '0; m_mem = '0; m_wb = '0;
            m_stall = 0; m_bub = 0; m_perr = 1'b0; m_clr = 1'b0;
            ex_q.delete();
        end else begin
            m_wb  = m_mem;
            m_mem = m_ex;
            m_ex  = (ex_q.size() > 0) ? ex_q.pop_front() : st_t'(0);
            if (st && m_stall < 15) m_stall++;
            if (st && m_bub < 15) m_bub++;
            if (pe) m_perr = 1'b1;
            m_clr = cl;
        end
    endtask

    task automatic do_reset();
        reset = 1'b1;
        set_in(4'd5, 1'b1, 1'b0, 1'b1, 1'b0, 1'b0);
        tick();
        tick();
        reset = 1'b0;
    endtask

    task automatic test_reset();
        do_reset();
        n_total++;
        if ({EX_RD, MEM_RD, WB_RD} !== 12'h000) $display("FAIL reset_rd: got %h want 000", {EX_RD, MEM_RD, WB_RD});
        else n_pass++;
        n_total++;
        if ({EX_RF_enable, MEM_RF_enable, WB_RF_enable, EX_load_instr, MEM_load_instr} !== 5'b0)
            $display("FAIL reset_flags: got %b want 00000",
                     {EX_RF_enable, MEM_RF_enable, WB_RF_enable, EX_load_instr, MEM_load_instr});
        else n_pass++;
        n_total++;
        if ({stall_cnt, bubble_cnt, protocol_err, IFID_clear} !== 10'b0)
            $display("FAIL reset_cnt: got stall=%0d bubble=%0d perr=%b clr=%b want 0 0 0 0",
                     stall_cnt, bubble_cnt, protocol_err, IFID_clear);
        else n_pass++;
        set_in(4'd5, 1'b1, 1'b0, 1'b1, 1'b0, 1'b0);
        tick();
        n_total++;
        if (EX_RD !== 4'd5 || EX_RF_enable !== 1'b1 || EX_RD !== m_ex.rd)
            $display("FAIL reset_release_ex: got rd=%0d we=%b want rd=5 we=1", EX_RD, EX_RF_enable);
        else n_pass++;
        tick();
        tick();
        n_total++;
        if (WB_RD !== 4'd5 || WB_RF_enable !== m_wb.we)
            $display("FAIL reset_release_wb: got rd=%0d we=%b want rd=5 we=%b", WB_RD, WB_RF_enable, m_wb.we);
        else n_pass++;
    endtask

    task automatic test_load_use();
        do_reset();
        set_in(4'd3, 1'b1, 1'b1, 1'b1, 1'b0, 1'b0);
        tick();
        set_in(4'd4, 1'b1, 1'b0, 1'b0, 1'b1, 1'b0);
        #1;
        n_total++;
        if (PC_LE !== 1'b0 || IFID_LE !== 1'b0)
            $display("FAIL lu_enables: got pc_le=%b ifid_le=%b want 0 0", PC_LE, IFID_LE);
        else n_pass++;
        tick();
        n_total++;
        if (EX_RD !== m_ex.rd || EX_RF_enable !== 1'b0 || EX_load_instr !== 1'b0 || EX_RD !== 4'd0)
            $display("FAIL lu_bubble: got rd=%0d we=%b ld=%b want 0 0 0", EX_RD, EX_RF_enable, EX_load_instr);
        else n_pass++;
        n_total++;
        if (MEM_RD !== 4'd3 || MEM_load_instr !== 1'b1 || MEM_RF_enable !== m_mem.we)
            $display("FAIL lu_mem: got rd=%0d ld=%b want 3 1", MEM_RD, MEM_load_instr);
        else n_pass++;
        n_total++;
        if (stall_cnt !== 4'd1 || bubble_cnt !== 4'd1 || int'(stall_cnt) != m_stall)
            $display("FAIL lu_counters: got stall=%0d bubble=%0d want 1 1", stall_cnt, bubble_cnt);
        else n_pass++;
        set_in(4'd4, 1'b1, 1'b0, 1'b1, 1'b0, 1'b0);
        #1;
        n_total++;
        if (PC_LE !== 1'b1 || IFID_LE !== 1'b1)
            $display("FAIL lu_resume_en: got pc_le=%b ifid_le=%b want 1 1", PC_LE, IFID_LE);
        else n_pass++;
        tick();
        n_total++;
        if (EX_RD !== m_ex.rd || EX_RF_enable !== m_ex.we || WB_RD !== m_wb.rd)
            $display("FAIL lu_resume: got ex=%0d we=%b wb=%0d want ex=%0d we=%b wb=%0d",
                     EX_RD, EX_RF_enable, WB_RD, m_ex.rd, m_ex.we, m_wb.rd);
        else n_pass++;
    endtask

    task automatic test_flush();
        set_in(4'd7, 1'b1, 1'b0, 1'b1, 1'b0, 1'b1);
        tick();
        n_total++;
        if (IFID_clear !== 1'b1 || IFID_clear !== m_clr)
            $display("FAIL flush_clear: got %b want 1", IFID_clear);
        else n_pass++;
        set_in(4'd8, 1'b1, 1'b0, 1'b1, 1'b0, 1'b0);
        tick();
        n_total++;
        if (IFID_clear !== 1'b0) $display("FAIL flush_one_cycle: got %b want 0", IFID_clear);
        else n_pass++;
        set_in(4'd9, 1'b1, 1'b0, 1'b0, 1'b1, 1'b1);
        #1;
        n_total++;
        if (PC_LE !== 1'b0) $display("FAIL flush_stall_pcle: got %b want 0", PC_LE);
        else n_pass++;
        tick();
        n_total++;
        if (IFID_clear !== 1'b0 || EX_RF_enable !== m_ex.we)
            $display("FAIL flush_during_stall: got clr=%b we=%b want 0 0", IFID_clear, EX_RF_enable);
        else n_pass++;
    endtask

    task automatic test_back_to_back();
        do_reset();
        for (int i = 1; i <= 4; i++) begin
            set_in(4'(i), 1'b1, 1'b0, 1'b1, 1'b0, 1'b0);
            tick();
            n_total++;
            if (EX_RD !== m_ex.rd || MEM_RD !== m_mem.rd || WB_RD !== m_wb.rd || EX_RF_enable !== 1'b1)
                $display("FAIL b2b_stage_%0d: got %0d/%0d/%0d want %0d/%0d/%0d", i,
                         EX_RD, MEM_RD, WB_RD, m_ex.rd, m_mem.rd, m_wb.rd);
            else n_pass++;
        end
        set_in(4'd6, 1'b1, 1'b0, 1'b1, 1'b0, 1'b0);
        n_total++;
        if (EX_RD !== 4'd4 || MEM_RD !== 4'd3 || WB_RD !== 4'd2)
            $display("FAIL b2b_432: got %0d/%0d/%0d want 4/3/2", EX_RD, MEM_RD, WB_RD);
        else n_pass++;
        n_total++;
        if (stall_cnt !== 4'd0 || bubble_cnt !== 4'd0 || protocol_err !== 1'b0)
            $display("FAIL b2b_counters: got %0d %0d %b want 0 0 0", stall_cnt, bubble_cnt, protocol_err);
        else n_pass++;
        tick();
    endtask

    task automatic test_protocol_err();
        set_in(4'd2, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0);
        tick();
        n_total++;
        if (protocol_err !== 1'b1 || EX_RF_enable !== 1'b0 || EX_RD !== m_ex.rd)
            $display("FAIL perr_set: got perr=%b we=%b rd=%0d want 1 0 0", protocol_err, EX_RF_enable, EX_RD);
        else n_pass++;
        for (int i = 0; i < 3; i++) begin
            set_in(4'(10 + i), 1'b1, 1'b0, 1'b1, 1'b0, 1'b0);
            tick();
        end
        n_total++;
        if (protocol_err !== m_perr || protocol_err !== 1'b1)
            $display("FAIL perr_sticky: got %b want 1", protocol_err);
        else n_pass++;
        n_total++;
        if (int'(bubble_cnt) != m_bub || WB_RD !== m_wb.rd)
            $display("FAIL perr_bubble_cnt: got %0d wb=%0d want %0d wb=%0d", bubble_cnt, WB_RD, m_bub, m_wb.rd);
        else n_pass++;
        do_reset();
        n_total++;
        if (protocol_err !== 1'b0) $display("FAIL perr_clear: got %b want 0", protocol_err);
        else n_pass++;
    endtask

    task automatic test_saturation();
        do_reset();
        for (int i = 0; i < 20; i++) begin
            set_in(4'(i), 1'b1, 1'b0, 1'b0, 1'b1, 1'b0);
            tick();
            if (i % 5 == 4) begin
                n_total++;
                if (int'(stall_cnt) != m_stall || int'(bubble_cnt) != m_bub)
                    $display("FAIL sat_step_%0d: got %0d %0d want %0d %0d", i, stall_cnt, bubble_cnt, m_stall, m_bub);
                else n_pass++;
            end
        end
        n_total++;
        if (stall_cnt !== 4'd15 || bubble_cnt !== 4'd15)
            $display("FAIL sat_final: got %0d %0d want 15 15", stall_cnt, bubble_cnt);
        else n_pass++;
        n_total++;
        if (WB_RF_enable !== 1'b0 || WB_RD !== 4'd0)
            $display("FAIL sat_wb_quiet: got we=%b rd=%0d want 0 0", WB_RF_enable, WB_RD);
        else n_pass++;
    endtask

    task automatic test_reset_mid_stall();
        set_in(4'd12, 1'b1, 1'b1, 1'b1, 1'b0, 1'b0);
        tick();
        set_in(4'd13, 1'b1, 1'b0, 1'b0, 1'b1, 1'b0);
        reset = 1'b1;
        tick();
        reset = 1'b0;
        n_total++;
        if ({EX_RD, MEM_RD, EX_load_instr, MEM_load_instr, stall_cnt} !== 14'b0)
            $display("FAIL reset_mid_stall: got ex=%0d mem=%0d ld=%b%b stall=%0d want all 0",
                     EX_RD, MEM_RD, EX_load_instr, MEM_load_instr, stall_cnt);
        else n_pass++;
    endtask

    initial begin
        reset = 1'b1;
        ID_RD = '0; ID_RF_enable = 1'b0; ID_load_instr = 1'b0;
        FW_LE_SIGNAL = 1'b1; FW_CU_MUX_SIGNAL = 1'b0; flush = 1'b0;
        test_reset();
        test_load_use();
        test_flush();
        test_back_to_back();
        test_protocol_err();
        test_saturation();
        test_reset_mid_stall();
        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
